// File: rtl/axi_rab_buffer_pkg.sv
// Shared types for the RAB prefetch buffer.
`default_nettype none

package axi_rab_buffer_pkg;

    typedef enum logic [0:0] {
        FLUSH_ALL       = 1'b0,
        FLUSH_KEEP_LAST = 1'b1
    } flush_mode_t;

endpackage

`default_nettype wire

// File: rtl/axi_buffer_rab_prefetch_ram.sv
// ram_2p_sync: one write port, one registered read port, array contents never reset.
`default_nettype none

module ram_2p_sync #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/axi_buffer_rab_prefetch.sv
// axi_buffer_rab_prefetch: RAM-backed FIFO with a two-entry prefetch (RAM output register + skid register).
`default_nettype none

module axi_buffer_rab_prefetch
    import axi_rab_buffer_pkg::*;
#(
    parameter int          DATA_WIDTH       = 32,
    parameter int          BUFFER_DEPTH     = 512,
    parameter int          LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH),
    parameter int          AFULL_THRESH     = BUFFER_DEPTH - 4,
    parameter flush_mode_t FLUSH_MODE       = FLUSH_KEEP_LAST
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        valid_in,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic                        ready_out,
    output logic                        valid_out,
    output logic [DATA_WIDTH-1:0]       data_out,
    input  logic                        ready_in,
    input  logic                        flush_entries,
    output logic [LOG_BUFFER_DEPTH:0]   level,
    output logic                        almost_full
);

    localparam logic [LOG_BUFFER_DEPTH-1:0] c_PTR_LAST = LOG_BUFFER_DEPTH'(BUFFER_DEPTH - 1);
    localparam logic [LOG_BUFFER_DEPTH:0]   c_DEPTH    = (LOG_BUFFER_DEPTH + 1)'(BUFFER_DEPTH);
    localparam logic [LOG_BUFFER_DEPTH:0]   c_AFULL    = (LOG_BUFFER_DEPTH + 1)'(AFULL_THRESH);

    logic [LOG_BUFFER_DEPTH-1:0] r_wr_ptr;
    logic [LOG_BUFFER_DEPTH-1:0] r_rd_ptr;
    logic [LOG_BUFFER_DEPTH:0]   r_level;
    logic                        r_q_v;
    logic                        r_skid_v;
    logic [DATA_WIDTH-1:0]       r_skid;

    logic                        w_accept;
    logic                        w_deliver;
    logic                        w_rd_en;
    logic [LOG_BUFFER_DEPTH:0]   w_pf_cnt;
    logic [LOG_BUFFER_DEPTH-1:0] w_wr_ptr_prev;
    logic [DATA_WIDTH-1:0]       w_q_data;

    function automatic logic [LOG_BUFFER_DEPTH-1:0] f_inc(input logic [LOG_BUFFER_DEPTH-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign ready_out     = (r_level < c_DEPTH) && !flush_entries;
    assign valid_out     = (r_q_v || r_skid_v) && !flush_entries;
    assign data_out      = r_skid_v ? r_skid : w_q_data;
    assign level         = r_level;
    assign almost_full   = (r_level >= c_AFULL);

    assign w_accept      = valid_in && ready_out;
    assign w_deliver     = valid_out && ready_in;
    assign w_pf_cnt      = (LOG_BUFFER_DEPTH + 1)'(r_q_v) + (LOG_BUFFER_DEPTH + 1)'(r_skid_v);
    assign w_wr_ptr_prev = (r_wr_ptr == '0) ? c_PTR_LAST : r_wr_ptr - 1'b1;

    // Entries not in the prefetch stage are still in RAM; prefetch whenever a slot is free.
    assign w_rd_en = (r_level > w_pf_cnt) && !(r_q_v && r_skid_v) && !flush_entries;

    ram_2p_sync #(
        .ADDR_WIDTH (LOG_BUFFER_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUFFER_DEPTH)
    ) u_ram (
        .clk       (clk),
        .rstn      (rstn),
        .i_wr_en   (w_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_q_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_q_v    <= 1'b0;
            r_skid_v <= 1'b0;
            r_skid   <= '0;
        end else if (flush_entries) begin
            r_q_v    <= 1'b0;
            r_skid_v <= 1'b0;
            // The newest beat is still intact in RAM, so re-reading it refills the prefetch.
            if ((FLUSH_MODE == FLUSH_KEEP_LAST) && (r_level != '0)) begin
                r_rd_ptr <= w_wr_ptr_prev;
                r_level  <= (LOG_BUFFER_DEPTH + 1)'(1);
            end else begin
                r_rd_ptr <= r_wr_ptr;
                r_level  <= '0;
            end
        end else begin
            if (w_accept) begin
                r_wr_ptr <= f_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            if (w_accept && !w_deliver) begin
                r_level <= r_level + 1'b1;
            end else if (!w_accept && w_deliver) begin
                r_level <= r_level - 1'b1;
            end

            if (r_skid_v) begin
                if (w_deliver) begin
                    r_skid_v <= 1'b0;
                end
            end else if (r_q_v) begin
                if (!w_deliver && w_rd_en) begin
                    r_skid_v <= 1'b1;
                    r_skid   <= w_q_data;
                end else if (w_deliver && !w_rd_en) begin
                    r_q_v <= 1'b0;
                end
            end else if (w_rd_en) begin
                r_q_v <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
